// File: rtl/uart_pkg.sv
// Shared UART receive definitions: state encoding, divisor limits and data-bit limits.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_e;

  localparam int unsigned MIN_DIV       = 7;
  localparam int unsigned DATA_BITS_MIN = 5;
  localparam int unsigned DATA_BITS_MAX = 8;

  // Clocks per bit minus one for a given system clock and baud rate.
  function automatic int unsigned default_div(input int unsigned clk_freq,
                                              input int unsigned baud);
    return clk_freq / baud - 1;
  endfunction

endpackage

// File: rtl/rx_sync_edge.sv
// Two-flop synchroniser for the asynchronous RX line plus a 1->0 edge detector.
module rx_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic rx_async_i,
  output logic line_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // NOTE: reset is synchronous, so it lives inside the clocked block and
  // only takes effect on a rising edge; idle-high reset avoids a false start.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make the three flops shift as a pipeline.
      meta_q <= rx_async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign line_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/rx_bit_timer.sv
// UART receive bit timer: start validation, 3-sample majority per bit, stop-bit check.
module rx_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned DIV_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             rx_in,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  input  logic [3:0]       data_bits,
  output logic             busy,
  output logic             bit_valid,
  output logic             rx_bit,
  output logic [2:0]       bit_idx,
  output logic             frame_done,
  output logic             frame_err,
  output logic             start_err,
  output logic             div_rej
);

  localparam logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(default_div(CLK_FREQ, BAUD));
  localparam logic [DIV_W-1:0] MIN_DIV_V   = DIV_W'(MIN_DIV);

  rx_state_e        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [3:0]       nbits_q, nbits_d;
  logic [2:0]       samp_q, samp_d;
  logic             rx_bit_q, rx_bit_d;
  logic             frame_err_q, frame_err_d;
  logic             bit_valid_q, bit_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             start_err_q, start_err_d;
  logic             div_rej_q, div_rej_d;

  logic             line;
  logic             fall;
  logic [DIV_W-1:0] half, half_m1, half_p1, half_p2;
  logic             wrap, at_maj, maj, nbits_legal;
  logic [2:0]       last_idx;

  rx_sync_edge u_sync (
    .clk        (clk),
    .rst        (rst),
    .rx_async_i (rx_in),
    .line_o     (line),
    .fall_o     (fall)
  );

  // div only changes in IDLE, so these stay constant across a frame.
  assign half        = div_q >> 1;
  assign half_m1     = half - DIV_W'(1);
  assign half_p1     = half + DIV_W'(1);
  assign half_p2     = half + DIV_W'(2);
  assign wrap        = (cnt_q == div_q);
  assign at_maj      = (cnt_q == half_p2);
  assign maj         = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
  assign last_idx    = 3'(nbits_q - 4'd1);
  assign nbits_legal = (data_bits >= 4'(DATA_BITS_MIN)) && (data_bits <= 4'(DATA_BITS_MAX));

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_d        = div_q;
    bit_idx_d    = bit_idx_q;
    nbits_d      = nbits_q;
    samp_d       = samp_q;
    rx_bit_d     = rx_bit_q;
    frame_err_d  = frame_err_q;
    bit_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    start_err_d  = 1'b0;
    div_rej_d    = 1'b0;

    if (div_load) begin
      if (state_q == ST_IDLE) div_d = (div_value < MIN_DIV_V) ? MIN_DIV_V : div_value;
      else if (enable)        div_rej_d = 1'b1;
    end

    if (state_q != ST_IDLE) begin
      cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
      if (cnt_q == half_m1) samp_d[0] = line;
      if (cnt_q == half)    samp_d[1] = line;
      if (cnt_q == half_p1) samp_d[2] = line;
    end

    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d = ST_START;
          cnt_d   = '0;
          nbits_d = nbits_legal ? data_bits : 4'(DATA_BITS_MAX);
        end
      end
      ST_START: begin
        if (at_maj && maj) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          start_err_d = 1'b1;
        end else if (wrap) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (at_maj) begin
          bit_valid_d = 1'b1;
          rx_bit_d    = maj;
        end
        if (wrap) begin
          if (bit_idx_q == last_idx) state_d = ST_STOP;
          else                       bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      ST_STOP: begin
        // Leaving at mid-stop lets a back-to-back start edge be caught.
        if (at_maj) begin
          frame_done_d = 1'b1;
          frame_err_d  = ~maj;
          state_d      = ST_IDLE;
          cnt_d        = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!enable) begin
      state_d      = ST_IDLE;
      cnt_d        = '0;
      bit_idx_d    = 3'd0;
      rx_bit_d     = rx_bit_q;
      frame_err_d  = frame_err_q;
      bit_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      start_err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      div_q        <= DEFAULT_DIV;
      bit_idx_q    <= 3'd0;
      nbits_q      <= 4'(DATA_BITS_MAX);
      samp_q       <= 3'b000;
      rx_bit_q     <= 1'b0;
      frame_err_q  <= 1'b0;
      bit_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      start_err_q  <= 1'b0;
      div_rej_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      bit_idx_q    <= bit_idx_d;
      nbits_q      <= nbits_d;
      samp_q       <= samp_d;
      rx_bit_q     <= rx_bit_d;
      frame_err_q  <= frame_err_d;
      bit_valid_q  <= bit_valid_d;
      frame_done_q <= frame_done_d;
      start_err_q  <= start_err_d;
      div_rej_q    <= div_rej_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign bit_valid  = bit_valid_q;
  assign rx_bit     = rx_bit_q;
  assign bit_idx    = bit_idx_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign start_err  = start_err_q;
  assign div_rej    = div_rej_q;

endmodule

// File: tb/tb_rx_bit_timer.sv
// Randomised scoreboard bench for rx_bit_timer: frames are modelled as bit lists and timings.
module tb_rx_bit_timer;

  localparam int DIV_W   = 16;
  localparam int DEF_CPB = 100_000_000 / 115200;  // clocks per bit at power-up

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             rx_in;
  logic             div_load;
  logic [DIV_W-1:0] div_value;
  logic [3:0]       data_bits;
  logic             busy, bit_valid, rx_bit, frame_done, frame_err, start_err, div_rej;
  logic [2:0]       bit_idx;

  rx_bit_timer #(.CLK_FREQ(100_000_000), .BAUD(115200), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .rx_in      (rx_in),
    .div_load   (div_load),
    .div_value  (div_value),
    .data_bits  (data_bits),
    .busy       (busy),
    .bit_valid  (bit_valid),
    .rx_bit     (rx_bit),
    .bit_idx    (bit_idx),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .start_err  (start_err),
    .div_rej    (div_rej)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic val;
    int   idx;
    int   spacing;  // 0 = first bit of a frame, spacing not checked
  } bit_exp_t;

  bit_exp_t bit_q[$];
  logic     done_q[$];
  int       rej_q[$];
  int       serr_exp     = 0;
  int       exp_cpb      = DEF_CPB;
  int       last_bit_cyc = 0;
  int       checks       = 0;
  int       errors       = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops expectations whenever the DUT presents an event.
  always @(negedge clk) begin
    bit_exp_t e;
    logic     d;
    int       r;
    if (bit_valid || frame_done || start_err)
      check("one_strobe", 32'(int'(bit_valid) + int'(frame_done) + int'(start_err)), 1);
    if (bit_valid) begin
      check("bit_expected", 32'(bit_q.size() > 0), 1);
      if (bit_q.size() > 0) begin
        e = bit_q.pop_front();
        check("rx_bit", 32'(rx_bit), 32'(e.val));
        check("bit_idx", 32'(bit_idx), 32'(e.idx));
        if (e.spacing != 0) check("bit_spacing", 32'(cyc - last_bit_cyc), 32'(e.spacing));
      end
      last_bit_cyc = cyc;
    end
    if (frame_done) begin
      check("done_expected", 32'(done_q.size() > 0), 1);
      if (done_q.size() > 0) begin
        d = done_q.pop_front();
        check("frame_err", 32'(frame_err), 32'(d));
      end
    end
    if (start_err) begin
      check("start_err_expected", 32'(serr_exp > 0), 1);
      if (serr_exp > 0) serr_exp--;
    end
    if (div_rej) begin
      check("rej_expected", 32'(rej_q.size() > 0), 1);
      if (rej_q.size() > 0) begin
        r = rej_q.pop_front();
        check("rej_cycle", 32'(cyc), 32'(r));
      end
    end
  end

  task automatic load_div(input int v);
    div_load  = 1'b1;
    div_value = DIV_W'(v);
    tick(1);
    div_load  = 1'b0;
    exp_cpb   = ((v < 7) ? 7 : v) + 1;
  endtask

  // abort_kind: 0 none, 1 enable low at bit 3, 2 reset at bit 3. rej_bit: -1 none.
  task automatic send_frame(input logic [7:0] data, input int nb_cfg, input logic stop_val,
                            input int abort_kind, input int rej_bit);
    int cpb  = exp_cpb;
    int nb   = (nb_cfg >= 5 && nb_cfg <= 8) ? nb_cfg : 8;
    int nexp = (abort_kind != 0) ? 3 : nb;
    data_bits = 4'(nb_cfg);
    for (int i = 0; i < nexp; i++) bit_q.push_back('{data[i], i, (i == 0) ? 0 : cpb});
    if (abort_kind == 0) done_q.push_back(~stop_val);
    rx_in = 1'b0;
    tick(cpb);
    for (int i = 0; i < nb; i++) begin
      rx_in = data[i];
      if (abort_kind != 0 && i == 3) begin
        tick(cpb / 4);
        if (abort_kind == 1) enable = 1'b0;
        else                 rst    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", 32'(busy), 0);
        if (abort_kind == 2) begin
          check("rst_bit_idx", 32'(bit_idx), 0);
          check("rst_rx_bit", 32'(rx_bit), 0);
          check("rst_frame_err", 32'(frame_err), 0);
        end
        tick(cpb - cpb / 4 - 1);
      end else if (i == rej_bit) begin
        tick(cpb / 2);
        div_load  = 1'b1;
        div_value = DIV_W'($urandom_range(0, 200));
        rej_q.push_back(cyc + 1);
        tick(1);
        div_load = 1'b0;
        tick(cpb - cpb / 2 - 1);
      end else begin
        tick(cpb);
      end
    end
    rx_in = stop_val;
    tick(cpb);
    rx_in = 1'b1;
    if (abort_kind != 0) begin
      tick(2);
      enable = 1'b1;
      rst    = 1'b1;
      if (abort_kind == 2) exp_cpb = DEF_CPB;
    end
  endtask

  initial begin
    #(10 * 80000);
    $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    enable    = 1'b0;
    rx_in     = 1'b1;
    div_load  = 1'b0;
    div_value = '0;
    data_bits = 4'd8;
    tick(3);
    @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_bit_valid", 32'(bit_valid), 0);
    check("reset_frame_done", 32'(frame_done), 0);
    check("reset_start_err", 32'(start_err), 0);
    check("reset_div_rej", 32'(div_rej), 0);
    check("reset_rx_bit", 32'(rx_bit), 0);
    check("reset_frame_err", 32'(frame_err), 0);
    check("reset_bit_idx", 32'(bit_idx), 0);
    rst    = 1'b1;
    enable = 1'b1;
    tick(4);

    // Default divisor, 8N1 0x55.
    send_frame(8'h55, 8, 1'b1, 0, -1);
    tick(2 * exp_cpb);

    // Short low glitch on an idle line.
    serr_exp++;
    rx_in = 1'b0;
    tick(200);
    rx_in = 1'b1;
    tick(700);
    @(negedge clk);
    check("glitch_busy", 32'(busy), 0);
    check("glitch_serr_seen", 32'(serr_exp), 0);
    tick(1);

    // Below-minimum divisor clamps to 8 clocks per bit.
    load_div(3);
    send_frame(8'hA3, 8, 1'b1, 0, -1);
    tick(2 * exp_cpb);

    // div_load mid-frame is rejected; later bit spacing proves div is unchanged.
    send_frame(8'h3C, 8, 1'b1, 0, 2);
    tick(2 * exp_cpb);

    // Five data bits with a low stop bit, then two back-to-back frames.
    send_frame(8'h16, 5, 1'b0, 0, -1);
    tick(2 * exp_cpb);
    send_frame(8'hC9, 8, 1'b1, 0, -1);
    send_frame(8'h5E, 7, 1'b1, 0, -1);
    tick(2 * exp_cpb);

    // Random divisors, widths (including illegal ones), payloads and stop levels.
    for (int n = 0; n < 12; n++) begin
      load_div($urandom_range(0, 40));
      send_frame(8'($urandom), $urandom_range(3, 10), 1'($urandom_range(0, 1)), 0, -1);
      tick(2 * exp_cpb);
    end

    // Enable dropped at bit 3, then a clean frame.
    load_div(19);
    send_frame(8'hB7, 8, 1'b1, 1, -1);
    tick(2 * exp_cpb);
    send_frame(8'h4D, 8, 1'b1, 0, -1);
    tick(2 * exp_cpb);

    // Reset at bit 3 restores the default divisor; next frame at power-up rate.
    send_frame(8'hE2, 6, 1'b1, 2, -1);
    tick(2 * exp_cpb);
    send_frame(8'h9A, 8, 1'b1, 0, -1);
    tick(2 * exp_cpb);

    check("bits_outstanding", 32'(bit_q.size()), 0);
    check("done_outstanding", 32'(done_q.size()), 0);
    check("rej_outstanding", 32'(rej_q.size()), 0);
    check("serr_outstanding", 32'(serr_exp), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
